// File: rtl/mon_exp_prep.sv
// Operand preparation for mon_exp: latches m/e/n, rejects bad operands,
// maps 1 and m into the Montgomery domain (R = 2^BITLEN) by BITLEN modular
// doublings, finds the MSB of e, writes x_bar/M_bar to the operand RAM and
// then launches mon_exp.
//
// Handshake: start is a level request sampled only in IDLE; exp_start, done
// and err are single-cycle pulses with no back-pressure. mem_own marks the
// two cycles in which wr_en/wr_addr/wr_data are driven by this block.
module mon_exp_prep #(
    parameter int BITLEN     = 256,
    parameter int LOG_BITLEN = 8,
    parameter int ABITS      = 8,
    parameter int DBITS      = 256,
    parameter int XBAR_ADDR  = 0,
    parameter int MBAR_ADDR  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BITLEN-1:0]     m,
    input  logic [BITLEN-1:0]     e,
    input  logic [BITLEN-1:0]     n,
    output logic                  busy,
    output logic                  mem_own,
    output logic [ABITS-1:0]      wr_addr,
    output logic [DBITS-1:0]      wr_data,
    output logic                  wr_en,
    output logic [LOG_BITLEN-1:0] e_idx,
    output logic                  exp_start,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        REDUCE = 3'd2,
        WRX    = 3'd3,
        WRM    = 3'd4,
        LAUNCH = 3'd5
    } state_t;

    state_t                state_q;
    state_t                state_d;

    logic [BITLEN-1:0]     m_q;
    logic [BITLEN-1:0]     e_q;
    logic [BITLEN-1:0]     n_q;
    logic [BITLEN-1:0]     x_q;
    logic [BITLEN-1:0]     y_q;
    logic [LOG_BITLEN-1:0] cnt_q;
    logic                  found_q;
    logic                  err_q;

    logic                  bad_ops;
    logic                  last_cnt;
    logic [LOG_BITLEN-1:0] bit_idx;
    logic [BITLEN-1:0]     e_shift;

    // One modular doubling; 2v < 2n fits in BITLEN+1 bits because v < n.
    function automatic logic [BITLEN-1:0] mod_double(input logic [BITLEN-1:0] v,
                                                     input logic [BITLEN-1:0] mod);
        logic [BITLEN:0] d;
        d = {v, 1'b0};
        if (d >= {1'b0, mod}) begin
            d = d - {1'b0, mod};
        end
        return d[BITLEN-1:0];
    endfunction

    // Operand checks and MSB-scan position, evaluated on the latched operands.
    always_comb begin
        bad_ops  = 1'b0;
        if (!n_q[0] || (n_q <= BITLEN'(1)) || (e_q < BITLEN'(2)) || (m_q >= n_q)) begin
            bad_ops = 1'b1;
        end
        last_cnt = (cnt_q == LOG_BITLEN'(BITLEN - 1));
        bit_idx  = LOG_BITLEN'(BITLEN - 1) - cnt_q;
        e_shift  = e_q >> bit_idx;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d   = state_q;
        busy      = (state_q != IDLE);
        mem_own   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        exp_start = 1'b0;
        err       = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = bad_ops ? IDLE : REDUCE;
            end
            REDUCE: begin
                if (last_cnt) begin
                    state_d = WRX;
                end
            end
            WRX: begin
                mem_own = 1'b1;
                wr_en   = 1'b1;
                wr_addr = ABITS'(XBAR_ADDR);
                wr_data = DBITS'(x_q);
                state_d = WRM;
            end
            WRM: begin
                mem_own = 1'b1;
                wr_en   = 1'b1;
                wr_addr = ABITS'(MBAR_ADDR);
                wr_data = DBITS'(y_q);
                state_d = LAUNCH;
            end
            LAUNCH: begin
                exp_start = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done = exp_start | err_q;
    end

    // Operand latch, Montgomery-domain conversion, MSB scan and error pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            e_idx   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q <= m;
                        e_q <= e;
                        n_q <= n;
                    end
                end
                CHECK: begin
                    if (bad_ops) begin
                        err_q <= 1'b1;
                    end else begin
                        x_q     <= BITLEN'(1);
                        y_q     <= m_q;
                        cnt_q   <= '0;
                        found_q <= 1'b0;
                    end
                end
                REDUCE: begin
                    x_q   <= mod_double(x_q, n_q);
                    y_q   <= mod_double(y_q, n_q);
                    cnt_q <= cnt_q + LOG_BITLEN'(1);
                    if (!found_q && e_shift[0]) begin
                        e_idx   <= bit_idx;
                        found_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
